// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end fetch stage. Holds the PC and drives the word-addressed,
// combinational-read instruction memory. Each cycle it may capture the
// returned word into a small in-order buffer. The head of that buffer is
// presented to decode. A branch/jump redirect flushes the buffer and
// restarts fetch at the new PC.
//
// Optional feature (compile-time macro FETCH_MISALIGN_TRAP_EN):
//   When the macro is defined, a redirect to a non-word-aligned target flushes
//   the buffer and parks the unit in a TRAP state. In that state the unit
//   presents one pseudo-entry, flagged on out_misalign, and then stays idle.
//   Only an aligned redirect resumes fetch.
//   When the macro is undefined, the two low bits of redirect_pc are dropped.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   DEPTH     buffer entries (power of two, >= 2)
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   imem_addr       byte address to instruction memory (the PC register)
//   imem_rd         instruction word for imem_addr, combinational
//   redirect_valid  flush and restart fetch this cycle
//   redirect_pc     target byte address for the redirect
//   out_valid       head entry valid
//   out_ready       decode accepts head entry
//   out_instr       head entry instruction
//   out_pc          head entry PC
//   out_pc_plus4    out_pc + 4, modulo 2^32
//   out_misalign    head is the misaligned-redirect pseudo-entry (macro only)
//   dbg_state       current FSM state, for observation
//
// Handshake: an entry moves to decode on every rising edge where out_valid
// and out_ready are both 1. While out_valid=1 and out_ready=0, the head
// outputs hold stable. out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        out_misalign,
`endif
  output logic [0:0]  dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_TRAP = 1'b1
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_pc;
  logic [31:0]        r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic               r_trap_pending;
  logic [31:0]        r_trap_pc;
  logic               w_redirect_misaligned;
`else
  logic               w_unused_redirect_lsbs;
`endif

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic               w_buf_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_buf_pop;
  logic               w_push;
  logic [31:0]        w_redirect_aligned;

  assign w_buf_valid = (r_count != '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = out_valid & out_ready;
  // Only a pop of a real buffered entry moves the read side. The TRAP
  // pseudo-entry lives outside the buffer.
  assign w_buf_pop   = w_pop & w_buf_valid;
  // A pop in the same cycle frees a slot, so a full buffer still accepts a push.
  assign w_push      = (r_state == S_RUN) & ~redirect_valid & (~w_full | w_pop);

  assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_redirect_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign imem_addr = r_pc;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      w_state_next = w_redirect_misaligned ? S_TRAP : S_RUN;
`else
      w_state_next = S_RUN;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // A misaligned target stops fetch, so the PC keeps its old value.
      if (!w_redirect_misaligned) begin
        r_pc <= w_redirect_aligned;
      end
`else
      r_pc <= w_redirect_aligned;
`endif
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // ---------------------------------------------------------------------------
  // In-order buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: any pop in this cycle is discarded along with the contents.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= r_pc;
        r_instr_mem[r_wr_ptr] <= imem_rd;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_buf_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_buf_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // ---------------------------------------------------------------------------
  // Misaligned-redirect pseudo-entry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trap_pending <= 1'b0;
      r_trap_pc      <= '0;
    end else if (redirect_valid) begin
      r_trap_pending <= w_redirect_misaligned;
      if (w_redirect_misaligned) begin
        r_trap_pc <= redirect_pc;
      end
    end else if (w_pop && (r_state == S_TRAP)) begin
      r_trap_pending <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Head presentation. When nothing is valid, the fields read as zero, so
  // out_pc_plus4 reads 4.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_instr = '0;
    out_pc    = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    out_misalign = 1'b0;
    if (r_state == S_TRAP) begin
      out_valid    = r_trap_pending;
      out_misalign = r_trap_pending;
      out_pc       = r_trap_pending ? r_trap_pc : 32'd0;
    end else
`endif
    if (w_buf_valid) begin
      out_valid = 1'b1;
      out_instr = r_instr_mem[r_rd_ptr];
      out_pc    = r_pc_mem[r_rd_ptr];
    end
  end

  assign out_pc_plus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Two instances share the clock and reset:
//   a: RESET_PC = 0, used for the main, stall, redirect, reset and trap cases
//   b: RESET_PC = FFFFFFF8, used for the PC wrap case
// Each instance has an expected queue that the stimulus fills. A negedge
// monitor per instance pops one entry for every accepted handshake and
// compares it with the head outputs.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [31:0] mem [64];

  logic [31:0] a_imem_addr, a_imem_rd, a_redirect_pc;
  logic        a_redirect_valid, a_out_valid, a_out_ready, a_mis;
  logic [31:0] a_out_instr, a_out_pc, a_out_pc_plus4;
  logic [0:0]  a_dbg_state;

  logic [31:0] b_imem_addr, b_imem_rd, b_redirect_pc;
  logic        b_redirect_valid, b_out_valid, b_out_ready, b_mis;
  logic [31:0] b_out_instr, b_out_pc, b_out_pc_plus4;
  logic [0:0]  b_dbg_state;

  assign a_imem_rd = mem[a_imem_addr[7:2]];
  assign b_imem_rd = mem[b_imem_addr[7:2]];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (a_imem_addr),
    .imem_rd        (a_imem_rd),
    .redirect_valid (a_redirect_valid),
    .redirect_pc    (a_redirect_pc),
    .out_valid      (a_out_valid),
    .out_ready      (a_out_ready),
    .out_instr      (a_out_instr),
    .out_pc         (a_out_pc),
    .out_pc_plus4   (a_out_pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
    .out_misalign   (a_mis),
`endif
    .dbg_state      (a_dbg_state)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (b_imem_addr),
    .imem_rd        (b_imem_rd),
    .redirect_valid (b_redirect_valid),
    .redirect_pc    (b_redirect_pc),
    .out_valid      (b_out_valid),
    .out_ready      (b_out_ready),
    .out_instr      (b_out_instr),
    .out_pc         (b_out_pc),
    .out_pc_plus4   (b_out_pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
    .out_misalign   (b_mis),
`endif
    .dbg_state      (b_dbg_state)
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign a_mis = 1'b0;
  assign b_mis = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard: entry = {misalign, pc[31:0], instr[31:0]}
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic mis, input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({mis, pc, instr});
  endtask

  task automatic push_b(input logic mis, input logic [31:0] pc, input logic [31:0] instr);
    exp_q_b.push_back({mis, pc, instr});
  endtask

  task automatic compare_entry(input string tag, input logic [64:0] e,
                               input logic mis, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] pc4);
    logic [31:0] e_pc4;
    e_pc4 = e[63:32] + 32'd4;
    check({tag, "_pc"},       pc,            e[63:32]);
    check({tag, "_instr"},    instr,         e[31:0]);
    check({tag, "_pc_plus4"}, pc4,           e_pc4);
    check({tag, "_misalign"}, {31'd0, mis},  {31'd0, e[64]});
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rst && a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected actual pc=%h instr=%h expected=none", a_out_pc, a_out_instr);
      end else begin
        compare_entry("a", exp_q.pop_front(), a_mis, a_out_pc, a_out_instr, a_out_pc_plus4);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && b_out_valid && b_out_ready) begin
      if (exp_q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected actual pc=%h instr=%h expected=none", b_out_pc, b_out_instr);
      end else begin
        compare_entry("b", exp_q_b.pop_front(), b_mis, b_out_pc, b_out_instr, b_out_pc_plus4);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Wait, one clock at a time, until the chosen queue drains. Return the
  // number of edges taken. Leave 1 time unit after the last edge.
  task automatic wait_empty(input bit use_b, input int budget, output int cycles);
    cycles = 0;
    while (((use_b ? exp_q_b.size() : exp_q.size()) != 0) && cycles < budget) begin
      @(posedge clk);
      cycles++;
    end
    if ((use_b ? exp_q_b.size() : exp_q.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_left expected=0", use_b ? exp_q_b.size() : exp_q.size());
    end
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_a(input logic [31:0] target);
    a_redirect_valid = 1'b1;
    a_redirect_pc    = target;
    step();
    a_redirect_valid = 1'b0;
    a_redirect_pc    = '0;
  endtask

  // Assert reset asynchronously, then release it 1 time unit after an edge.
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    rst = 1'b0;
    a_redirect_valid = 1'b0; a_redirect_pc = '0; a_out_ready = 1'b1;
    b_redirect_valid = 1'b0; b_redirect_pc = '0; b_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_valid",     {31'd0, a_out_valid}, 32'd0);
    check("rst_instr",     a_out_instr,          32'd0);
    check("rst_pc",        a_out_pc,             32'd0);
    check("rst_pc_plus4",  a_out_pc_plus4,       32'd4);
    check("rst_imem_addr", a_imem_addr,          32'd0);
    check("rst_b_addr",    b_imem_addr,          32'hFFFF_FFF8);
    check("rst_b_pc4",     b_out_pc_plus4,       32'd4);
    check("rst_state",     {31'd0, a_dbg_state}, 32'd0);

    // Reset release, free-running decode
    push_a(1'b0, 32'h0, 32'h11);
    push_a(1'b0, 32'h4, 32'h22);
    push_a(1'b0, 32'h8, 32'h33);
    push_a(1'b0, 32'hC, 32'h44);
    rst = 1'b1;
    check("release_valid0", {31'd0, a_out_valid}, 32'd0);
    step();
    check("first_valid", {31'd0, a_out_valid}, 32'd1);
    wait_empty(1'b0, 20, cyc);
    check("throughput_cycles", cyc, 32'd4);
    a_out_ready = 1'b0;
    repeat (2) step();
    check("full_valid", {31'd0, a_out_valid}, 32'd1);
    check("full_addr",  a_imem_addr,          32'h18);
    check("full_head",  a_out_pc,             32'h10);

    // Asynchronous reset mid-stream with a full buffer
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, a_out_valid}, 32'd0);
    check("async_rst_addr",  a_imem_addr,          32'd0);
    check("async_rst_pc",    a_out_pc,             32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Decode stalled for 5 cycles: buffer fills, fetch freezes
    repeat (5) step();
    check("stall_addr",  a_imem_addr,          32'h8);
    check("stall_instr", a_out_instr,          32'h11);
    check("stall_valid", {31'd0, a_out_valid}, 32'd1);
    check("stall_pc",    a_out_pc,             32'h0);
    push_a(1'b0, 32'h0, 32'h11);
    push_a(1'b0, 32'h4, 32'h22);
    push_a(1'b0, 32'h8, 32'h33);
    a_out_ready = 1'b1;
    wait_empty(1'b0, 20, cyc);
    a_out_ready = 1'b0;
    check("refill_cycles", cyc, 32'd3);

    // Redirect while the buffer holds two entries (C and 10)
    check("pre_redir_head", a_out_pc, 32'hC);
    redirect_a(32'h40);
    check("redir_valid0", {31'd0, a_out_valid}, 32'd0);
    check("redir_addr",   a_imem_addr,          32'h40);
    push_a(1'b0, 32'h40, 32'hA000_0010);
    push_a(1'b0, 32'h44, 32'hA000_0011);
    step();
    check("redir_valid1", {31'd0, a_out_valid}, 32'd1);
    check("redir_head",   a_out_pc,             32'h40);
    a_out_ready = 1'b1;
    wait_empty(1'b0, 20, cyc);
    a_out_ready = 1'b0;

`ifndef FETCH_MISALIGN_TRAP_EN
    // Misaligned target is silently word-aligned
    redirect_a(32'h4A);
    check("align_addr", a_imem_addr, 32'h48);
    push_a(1'b0, 32'h48, 32'hA000_0012);
    step();
    a_out_ready = 1'b1;
    wait_empty(1'b0, 20, cyc);
    a_out_ready = 1'b0;
`else
    // Misaligned redirect enters TRAP after the buffer has filled with 0 and 4.
    pulse_reset();
    repeat (3) step();
    check("trap_pre_addr", a_imem_addr, 32'h8);
    redirect_a(32'h42);
    check("trap_valid",    {31'd0, a_out_valid}, 32'd1);
    check("trap_mis",      {31'd0, a_mis},       32'd1);
    check("trap_pc",       a_out_pc,             32'h42);
    check("trap_instr",    a_out_instr,          32'd0);
    check("trap_addr",     a_imem_addr,          32'h8);
    check("trap_state",    {31'd0, a_dbg_state}, 32'd1);
    push_a(1'b1, 32'h42, 32'h0);
    a_out_ready = 1'b1;
    wait_empty(1'b0, 20, cyc);
    check("trap_done_valid", {31'd0, a_out_valid}, 32'd0);
    repeat (2) step();
    check("trap_idle_valid", {31'd0, a_out_valid}, 32'd0);
    check("trap_idle_addr",  a_imem_addr,          32'h8);
    a_out_ready = 1'b0;
    redirect_a(32'h80);
    check("resume_valid0", {31'd0, a_out_valid}, 32'd0);
    check("resume_addr",   a_imem_addr,          32'h80);
    check("resume_state",  {31'd0, a_dbg_state}, 32'd0);
    push_a(1'b0, 32'h80, 32'hA000_0020);
    step();
    check("resume_valid1", {31'd0, a_out_valid}, 32'd1);
    check("resume_pc",     a_out_pc,             32'h80);
    a_out_ready = 1'b1;
    wait_empty(1'b0, 20, cyc);
    a_out_ready = 1'b0;
`endif

    // PC wrap on instance b
    rst = 1'b0;
    #1;
    check("b_rst_addr",  b_imem_addr,          32'hFFFF_FFF8);
    check("b_rst_valid", {31'd0, b_out_valid}, 32'd0);
    push_b(1'b0, 32'hFFFF_FFF8, 32'hA000_003E);
    push_b(1'b0, 32'hFFFF_FFFC, 32'hA000_003F);
    push_b(1'b0, 32'h0000_0000, 32'h11);
    @(posedge clk);
    #1;
    rst = 1'b1;
    b_out_ready = 1'b1;
    wait_empty(1'b1, 20, cyc);
    b_out_ready = 1'b0;
    check("b_wrap_cycles", cyc, 32'd4);

    check("a_queue_left", exp_q.size(),   32'd0);
    check("b_queue_left", exp_q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
